jtframe_pocket_vout: RTL and testbench
======================================

Name: jtframe_pocket_vout

Overview:
- Parametrised video output stage for the Analogue Pocket.
- Takes scan-doubled RGB and syncs, plus a pixel clock enable, and produces the Pocket video bus: 24-bit RGB, pixel clock, 90°-shifted pixel clock, DE, single-pixel HS/VS pulses and skip.
- Generalises the fixed 8-bit, divide-by-2 path. Adds a configurable divider, colour width, sync polarity, DE source, and a lock detector that measures the enable period before it drives a phase-shifted clock.
- Sits between the scan doubler and the Pocket APF video pins.

Parameters:
- CW, 8: colour bits per input channel, range 4..8; expanded to 8 bits at the output.
- DIV, 2: pxl2_cen pulses per output pixel; even, range 2..16.
- CNTW, 6: width of the enable-period counter.
- DEMODE, 0: DE source. 0 = derived (!vs & !hs); 1 = scan2x_de.
- HSPOL, 1: active level of scan2x_hs (1 = active high).
- VSPOL, 1: active level of scan2x_vs (1 = active high).
- LOCKN, 3: number of consecutive equal period measurements needed to declare lock.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pxl2_cen  in  1  scan-doubler pixel clock enable
- scan2x_r  in  CW  red
- scan2x_g  in  CW  green
- scan2x_b  in  CW  blue
- scan2x_hs  in  1  horizontal sync, polarity per HSPOL
- scan2x_vs  in  1  vertical sync, polarity per VSPOL
- scan2x_de  in  1  data enable, used only when DEMODE=1
- pck_rgb  out  24  {R,G,B}, 8 bits each
- pck_rgb_clk  out  1  output pixel clock
- pck_rgb_clkq  out  1  pck_rgb_clk delayed by a quarter period
- pck_de  out  1  data enable
- pck_skip  out  1  skip flag, constant 0
- pck_hs  out  1  one-pixel pulse at HS active edge
- pck_vs  out  1  one-pixel pulse at VS active edge
- pck_lock  out  1  period lock status

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs 0. Internal counters 0, divider phase 0, state UNLOCK.
  - Asserting rst mid-frame takes effect on the next clk edge.
  - The first pixel after release needs a full DIV cen pulses.
- Period counter (pcnt, CNTW bits):
  - On pxl2_cen: pcnt <= 0. Otherwise pcnt increments, saturating at all-ones.
  - On pxl2_cen: per <= pcnt and the match counter is updated.
    - If pcnt == per and pcnt is not saturated: match counter increments, saturating at LOCKN.
    - Otherwise: match counter <= 0.
- Lock FSM:
  - UNLOCK -> LOCK when the match counter reaches LOCKN.
  - LOCK -> UNLOCK on any mismatch or on pcnt saturation, on the same clk.
  - pck_lock = (state == LOCK).
- Divider:
  - dcnt counts pxl2_cen pulses, modulo DIV.
  - pck_rgb_clk toggles when dcnt == DIV/2-1 and when dcnt == DIV-1, each time on a cen.
- Data capture:
  - Happens on the cen that makes pck_rgb_clk rise.
  - pck_rgb <= colour, each channel expanded by MSB replication: {c, c[CW-1 -: 8-CW]}. CW=8 passes straight through.
  - DE, HS and VS are sampled on the same cen.
  - Pipeline latency is 1 clk from the cen.
- Syncs:
  - The inputs are normalised to active-high using HSPOL/VSPOL.
  - pck_hs = hs & ~hs_prev, and pck_vs likewise, where the previous value is the one latched at the prior capture.
  - Each pulse therefore lasts exactly one output pixel.
  - A sync active at reset release produces no pulse.
- DE:
  - DEMODE=0: pck_de = !hs & !vs (normalised).
  - DEMODE=1: pck_de = scan2x_de.
- Quarter clock:
  - tcnt counts clk cycles since the last pck_rgb_clk toggle and resets on the toggle.
  - Q = ((per+1)*DIV)>>2, computed with width CNTW+4.
  - LOCK: pck_rgb_clkq <= pck_rgb_clk when tcnt == Q-1. If Q == 0, it follows pck_rgb_clk with one clk of delay.
  - UNLOCK: pck_rgb_clkq <= pck_rgb_clk every clk, giving 0° phase plus one clk.
  - When a toggle and tcnt == Q-1 occur on the same clk, clkq takes the pre-toggle rgb_clk value and tcnt restarts.
- pck_skip is held at 0.

Decomposition:
- Shared package jtframe_pocket_pkg holds:
  - lock state encoding (UNLOCK = 1'b0, LOCK = 1'b1);
  - localparam PCK_CW = 8;
  - the colour-expansion function.
- One sub-module, jtframe_pocket_phase, contains the period counter, lock FSM, tcnt and clkq generation.
  - Inputs: clk, rst, cen, rgb_clk.
  - Outputs: clkq, lock.
- The top level keeps the divider, capture and sync logic.

Test Plan:
- Lock and phase: DIV=2, cen every 4 clk, stable. pck_lock rises on the 4th cen after reset (LOCKN=3). pck_rgb_clk has a period of 8 clk, and pck_rgb_clkq lags it by exactly 2 clk.
- Divider: DIV=4, cen every 2 clk. pck_rgb_clk is high for 2 cen and low for 2 cen. RGB updates once per 8 clk, only on rising-edge cens.
- Colour expansion: CW=5, r=5'b10110. pck_rgb[23:16] = 8'hB5. CW=8, input 0x3C passes through unchanged.
- Syncs and DE:
  - HSPOL=0, hs low for 10 output pixels. pck_hs is high for exactly 1 pixel at the falling edge of the input.
  - DEMODE=0: pck_de is low during sync.
  - DEMODE=1: pck_de tracks scan2x_de with 1-pixel latency.
- Lock loss: the cen period jumps from 4 to 6 clk. pck_lock drops on the first 6-clk cen, clkq reverts to rgb_clk+1 clk, and lock returns after 3 more matching 6-clk periods with a 3-clk lag.
- Reset and stall:
  - rst pulsed mid-line: all outputs are 0 next clk.
  - cen stopped for 70 clk (CNTW=6): pcnt saturates and pck_lock drops.

Source files
------------

// File: rtl/jtframe_pocket_pkg.sv
// rtl/jtframe_pocket_pkg.sv - shared types and helpers for the Pocket video output stage
package jtframe_pocket_pkg;

  typedef enum logic {
    UNLOCK = 1'b0,
    LOCK   = 1'b1
  } lock_state_e;

  localparam int PCK_CW = 8;

  // c_msb holds a cw-bit channel left-aligned; OR-ing its top bits into the
  // vacated low end is MSB replication, valid while cw >= PCK_CW/2.
  function automatic logic [PCK_CW-1:0] expand_colour(input logic [PCK_CW-1:0] c_msb,
                                                      input int cw);
    expand_colour = c_msb | (c_msb >> cw);
  endfunction

endpackage

// File: rtl/jtframe_pocket_phase.sv
// rtl/jtframe_pocket_phase.sv - enable-period lock detector and quarter-phase pixel clock
module jtframe_pocket_phase
  import jtframe_pocket_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int CNTW  = 6,
  parameter int LOCKN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic rgb_clk,
  output logic clkq,
  output logic lock
);

  localparam int TW = CNTW + 4;
  localparam int MW = $clog2(LOCKN + 1);

  logic [CNTW-1:0] pcnt_q, pcnt_d, per_q, per_d;
  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d, tcnt_eff, q_len;
  lock_state_e     state_q, state_d;
  logic            rgb_prev_q, clkq_q, clkq_d;
  logic            sat, match, toggle;

  assign sat    = &pcnt_q;
  assign match  = (pcnt_q == per_q) && !sat;
  assign q_len  = TW'(((32'(per_q) + 32'd1) * DIV) >> 2);
  // rgb_clk is itself a flop, so its toggle is seen one clk late; forcing the
  // count to zero in that cycle makes the lag equal Q clk after the real toggle.
  assign toggle   = rgb_clk ^ rgb_prev_q;
  assign tcnt_eff = toggle ? '0 : tcnt_q;

  always_comb begin
    pcnt_d  = cen ? '0 : (sat ? pcnt_q : pcnt_q + 1'b1);
    per_d   = cen ? pcnt_q : per_q;
    mcnt_d  = mcnt_q;
    state_d = state_q;
    tcnt_d  = (&tcnt_eff) ? tcnt_eff : tcnt_eff + 1'b1;
    clkq_d  = clkq_q;

    if (cen) begin
      if (!match)
        mcnt_d = '0;
      else if (mcnt_q != MW'(LOCKN))
        mcnt_d = mcnt_q + 1'b1;
    end

    case (state_q)
      UNLOCK: if (cen && match && mcnt_d == MW'(LOCKN)) state_d = LOCK;
      LOCK:   if (sat || (cen && !match)) state_d = UNLOCK;
      default: state_d = UNLOCK;
    endcase

    if (state_q == UNLOCK || q_len == '0)
      clkq_d = rgb_clk;
    else if (tcnt_eff == q_len - 1'b1)
      clkq_d = rgb_clk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q     <= '0;
      per_q      <= '0;
      mcnt_q     <= '0;
      tcnt_q     <= '0;
      state_q    <= UNLOCK;
      rgb_prev_q <= 1'b0;
      clkq_q     <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      per_q      <= per_d;
      mcnt_q     <= mcnt_d;
      tcnt_q     <= tcnt_d;
      state_q    <= state_d;
      rgb_prev_q <= rgb_clk;
      clkq_q     <= clkq_d;
    end
  end

  assign clkq = clkq_q;
  assign lock = (state_q == LOCK);

endmodule

// File: rtl/jtframe_pocket_vout.sv
// rtl/jtframe_pocket_vout.sv - scan-doubler to Analogue Pocket video bus adapter
module jtframe_pocket_vout
  import jtframe_pocket_pkg::*;
#(
  parameter int CW     = 8,
  parameter int DIV    = 2,
  parameter int CNTW   = 6,
  parameter int DEMODE = 0,
  parameter int HSPOL  = 1,
  parameter int VSPOL  = 1,
  parameter int LOCKN  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl2_cen,
  input  logic [CW-1:0] scan2x_r,
  input  logic [CW-1:0] scan2x_g,
  input  logic [CW-1:0] scan2x_b,
  input  logic          scan2x_hs,
  input  logic          scan2x_vs,
  input  logic          scan2x_de,
  output logic [23:0]   pck_rgb,
  output logic          pck_rgb_clk,
  output logic          pck_rgb_clkq,
  output logic          pck_de,
  output logic          pck_skip,
  output logic          pck_hs,
  output logic          pck_vs,
  output logic          pck_lock
);

  localparam int DW = $clog2(DIV);

  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic              rgb_clk_q, rgb_clk_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic              hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic              hs_n, vs_n, rise, fall;
  logic [PCK_CW-1:0] r_al, g_al, b_al;

  assign hs_n = (HSPOL != 0) ? scan2x_hs : ~scan2x_hs;
  assign vs_n = (VSPOL != 0) ? scan2x_vs : ~scan2x_vs;
  assign rise = pxl2_cen && (dcnt_q == DW'(DIV/2 - 1));
  assign fall = pxl2_cen && (dcnt_q == DW'(DIV - 1));

  assign r_al = PCK_CW'(scan2x_r) << (PCK_CW - CW);
  assign g_al = PCK_CW'(scan2x_g) << (PCK_CW - CW);
  assign b_al = PCK_CW'(scan2x_b) << (PCK_CW - CW);

  always_comb begin
    dcnt_d    = dcnt_q;
    rgb_clk_d = rgb_clk_q;
    rgb_d     = rgb_q;
    de_d      = de_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;

    if (pxl2_cen)
      dcnt_d = (dcnt_q == DW'(DIV - 1)) ? '0 : dcnt_q + 1'b1;
    if (rise || fall)
      rgb_clk_d = ~rgb_clk_q;

    if (rise) begin
      rgb_d     = {expand_colour(r_al, CW), expand_colour(g_al, CW), expand_colour(b_al, CW)};
      hs_d      = hs_n & ~hs_prev_q;
      vs_d      = vs_n & ~vs_prev_q;
      hs_prev_d = hs_n;
      vs_prev_d = vs_n;
      de_d      = (DEMODE != 0) ? scan2x_de : (~hs_n & ~vs_n);
    end
  end

  // Sync history resets as "active" so a sync already asserted at release
  // cannot masquerade as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q    <= '0;
      rgb_clk_q <= 1'b0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      dcnt_q    <= dcnt_d;
      rgb_clk_q <= rgb_clk_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  jtframe_pocket_phase #(
    .DIV   (DIV),
    .CNTW  (CNTW),
    .LOCKN (LOCKN)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .cen     (pxl2_cen),
    .rgb_clk (rgb_clk_q),
    .clkq    (pck_rgb_clkq),
    .lock    (pck_lock)
  );

  assign pck_rgb     = rgb_q;
  assign pck_rgb_clk = rgb_clk_q;
  assign pck_de      = de_q;
  assign pck_hs      = hs_q;
  assign pck_vs      = vs_q;
  assign pck_skip    = 1'b0;

endmodule

// File: tb/tb_jtframe_pocket_vout.sv
// tb/tb_jtframe_pocket_vout.sv - directed bench: 8-bit/DIV2/HS-low and 5-bit/DIV4/DE-input instances
module tb_jtframe_pocket_vout;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [23:0] rgb0;
    logic [4:0]  r1;
    logic [4:0]  g1;
    logic [4:0]  b1;
    logic        de1;
    logic        e_hs;
    logic        e_vs;
    logic        e_de0;
    logic [23:0] e_rgb1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cen0, cen1;
  logic [7:0]  r0, g0, b0;
  logic        hs0, vs0, de0_in;
  logic [4:0]  r1, g1, b1;
  logic        hs1, vs1, de1;
  logic [23:0] rgb0_o, rgb1_o;
  logic        rgbclk0, clkq0, de0_o, skip0, hs0_o, vs0_o, lock0;
  logic        rgbclk1, clkq1, de1_o, skip1, hs1_o, vs1_o, lock1;

  int   total = 0, bad = 0;
  int   ph0, ph1, per0, lag_chk;
  logic cen0_en, exp_rgb0;
  logic hist [0:3];
  vec_t tv [14];
  logic [23:0] prev0, prev1;

  jtframe_pocket_vout #(.CW(8), .DIV(2), .CNTW(6), .DEMODE(0), .HSPOL(0), .VSPOL(1), .LOCKN(3)) u0 (
    .clk(clk), .rst(rst), .pxl2_cen(cen0), .scan2x_r(r0), .scan2x_g(g0), .scan2x_b(b0),
    .scan2x_hs(hs0), .scan2x_vs(vs0), .scan2x_de(de0_in), .pck_rgb(rgb0_o), .pck_rgb_clk(rgbclk0),
    .pck_rgb_clkq(clkq0), .pck_de(de0_o), .pck_skip(skip0), .pck_hs(hs0_o), .pck_vs(vs0_o),
    .pck_lock(lock0));

  jtframe_pocket_vout #(.CW(5), .DIV(4), .CNTW(6), .DEMODE(1), .HSPOL(1), .VSPOL(1), .LOCKN(3)) u1 (
    .clk(clk), .rst(rst), .pxl2_cen(cen1), .scan2x_r(r1), .scan2x_g(g1), .scan2x_b(b1),
    .scan2x_hs(hs1), .scan2x_vs(vs1), .scan2x_de(de1), .pck_rgb(rgb1_o), .pck_rgb_clk(rgbclk1),
    .pck_rgb_clkq(clkq1), .pck_de(de1_o), .pck_skip(skip1), .pck_hs(hs1_o), .pck_vs(vs1_o),
    .pck_lock(lock1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clk: drive cens from the phase counters, sample 1 time unit after the edge,
  // track the expected u0 pixel clock and optionally its expected quarter-phase copy.
  task automatic tick();
    cen0 = cen0_en && !rst && (ph0 == per0 - 1);
    cen1 = !rst && (ph1 == 1);
    @(posedge clk);
    #1;
    if (rst) begin
      ph0 = 0; ph1 = 0; exp_rgb0 = 1'b0;
    end else begin
      ph0 = cen0 ? 0 : ph0 + 1;
      ph1 = cen1 ? 0 : ph1 + 1;
      if (cen0) exp_rgb0 = ~exp_rgb0;
    end
    for (int k = 3; k > 0; k--) hist[k] = rst ? 1'b0 : hist[k-1];
    hist[0] = exp_rgb0;
    chk("rgb_clk0", 32'(rgbclk0), 32'(exp_rgb0));
    if (lag_chk != 0)
      chk($sformatf("clkq0_lag%0d", lag_chk), 32'(clkq0), 32'(hist[lag_chk]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgb0"}, 32'(rgb0_o), 32'd0);
    chk({tag, "_rgb1"}, 32'(rgb1_o), 32'd0);
    chk({tag, "_outs0"}, 32'({rgbclk0, clkq0, de0_o, skip0, hs0_o, vs0_o, lock0}), 32'd0);
    chk({tag, "_outs1"}, 32'({rgbclk1, clkq1, de1_o, skip1, hs1_o, vs1_o, lock1}), 32'd0);
  endtask

  initial begin
    //        hs    vs    rgb0        r1        g1        b1        de1   e_hs  e_vs  e_de0 e_rgb1
    tv[0]  = '{1'b1, 1'b0, 24'h3CA500, 5'b10110, 5'b00000, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b1, 24'hB500FF};
    tv[1]  = '{1'b0, 1'b0, 24'h123456, 5'b00001, 5'b10000, 5'b01111, 1'b0, 1'b1, 1'b0, 1'b0, 24'h08847B};
    tv[2]  = '{1'b0, 1'b0, 24'hFFFFFF, 5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF};
    tv[3]  = '{1'b0, 1'b0, 24'h000000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tv[4]  = '{1'b0, 1'b0, 24'h800001, 5'b10000, 5'b00001, 5'b10110, 1'b1, 1'b0, 1'b0, 1'b0, 24'h8408B5};
    tv[5]  = '{1'b0, 1'b0, 24'h7F7F7F, 5'b01111, 5'b01111, 5'b01111, 1'b0, 1'b0, 1'b0, 1'b0, 24'h7B7B7B};
    tv[6]  = '{1'b0, 1'b0, 24'hC0FFEE, 5'b00010, 5'b00100, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 24'h102142};
    tv[7]  = '{1'b0, 1'b0, 24'h0F0F0F, 5'b11000, 5'b00110, 5'b10101, 1'b0, 1'b0, 1'b0, 1'b0, 24'hC631AD};
    tv[8]  = '{1'b0, 1'b0, 24'hABCDEF, 5'b01010, 5'b10011, 5'b11100, 1'b1, 1'b0, 1'b0, 1'b0, 24'h529CE7};
    tv[9]  = '{1'b0, 1'b0, 24'h555555, 5'b00011, 5'b11110, 5'b00101, 1'b0, 1'b0, 1'b0, 1'b0, 24'h18F729};
    tv[10] = '{1'b0, 1'b0, 24'hAAAAAA, 5'b10001, 5'b01110, 5'b11011, 1'b1, 1'b0, 1'b0, 1'b0, 24'h8C73DE};
    tv[11] = '{1'b1, 1'b1, 24'h010203, 5'b00111, 5'b01001, 5'b10010, 1'b0, 1'b0, 1'b1, 1'b0, 24'h394A94};
    tv[12] = '{1'b1, 1'b1, 24'hFEDCBA, 5'b11101, 5'b10100, 5'b01100, 1'b1, 1'b0, 1'b0, 1'b0, 24'hEFA563};
    tv[13] = '{1'b1, 1'b0, 24'h3C3C3C, 5'b10110, 5'b01101, 5'b11010, 1'b1, 1'b0, 1'b0, 1'b1, 24'hB56BD6};

    rst = 1'b1; cen0 = 1'b0; cen1 = 1'b0;
    r0 = '0; g0 = '0; b0 = '0; hs0 = 1'b1; vs0 = 1'b0; de0_in = 1'b0;
    r1 = '0; g1 = '0; b1 = '0; hs1 = 1'b0; vs1 = 1'b0; de1 = 1'b0;
    ph0 = 0; ph1 = 0; per0 = 4; cen0_en = 1'b1; lag_chk = 0; exp_rgb0 = 1'b0;
    for (int k = 0; k < 4; k++) hist[k] = 1'b0;
    prev0 = '0; prev1 = '0;

    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;

    // Lock acquisition: cen every 4 clk, first cen sees pcnt=3
    repeat (12) tick();
    chk("lock_after_cen3", 32'(lock0), 32'd0);
    repeat (4) tick();
    chk("lock_after_cen4", 32'(lock0), 32'd1);
    lag_chk = 2;

    // Pixel table: each vector is one 8-clk output pixel for both instances
    for (int i = 0; i < 14; i++) begin
      {r0, g0, b0} = tv[i].rgb0;
      hs0 = tv[i].hs; vs0 = tv[i].vs;
      r1 = tv[i].r1; g1 = tv[i].g1; b1 = tv[i].b1; de1 = tv[i].de1;
      repeat (2) tick();
      chk($sformatf("v%0d_clk1_lo_a", i), 32'(rgbclk1), 32'd0);
      chk($sformatf("v%0d_rgb1_hold", i), 32'(rgb1_o), 32'(prev1));
      chk($sformatf("v%0d_rgb0_hold", i), 32'(rgb0_o), 32'(prev0));
      repeat (2) tick();
      chk($sformatf("v%0d_clk1_hi_a", i), 32'(rgbclk1), 32'd1);
      chk($sformatf("v%0d_rgb1", i), 32'(rgb1_o), 32'(tv[i].e_rgb1));
      chk($sformatf("v%0d_rgb0", i), 32'(rgb0_o), 32'(tv[i].rgb0));
      repeat (2) tick();
      chk($sformatf("v%0d_clk1_hi_b", i), 32'(rgbclk1), 32'd1);
      repeat (2) tick();
      chk($sformatf("v%0d_clk1_lo_b", i), 32'(rgbclk1), 32'd0);
      chk($sformatf("v%0d_hs0", i), 32'(hs0_o), 32'(tv[i].e_hs));
      chk($sformatf("v%0d_vs0", i), 32'(vs0_o), 32'(tv[i].e_vs));
      chk($sformatf("v%0d_de0", i), 32'(de0_o), 32'(tv[i].e_de0));
      chk($sformatf("v%0d_de1", i), 32'(de1_o), 32'(tv[i].de1));
      chk($sformatf("v%0d_rgb1_end", i), 32'(rgb1_o), 32'(tv[i].e_rgb1));
      prev0 = tv[i].rgb0;
      prev1 = tv[i].e_rgb1;
    end

    // Lock loss: cen period 4 -> 6, relock after three matching periods
    per0 = 6;
    repeat (5) tick();
    chk("lock_before_6clk_cen", 32'(lock0), 32'd1);
    tick();
    chk("lock_lost_6clk_cen", 32'(lock0), 32'd0);
    lag_chk = 1;
    repeat (17) tick();
    chk("lock_still_lost", 32'(lock0), 32'd0);
    tick();
    chk("lock_regained", 32'(lock0), 32'd1);
    lag_chk = 3;
    repeat (24) tick();

    // Stall: no cen for 70 clk saturates the period counter
    lag_chk = 0;
    cen0_en = 1'b0;
    repeat (40) tick();
    chk("lock_stall_40", 32'(lock0), 32'd1);
    repeat (30) tick();
    chk("lock_stall_70", 32'(lock0), 32'd0);

    // Mid-line reset, then the first pixel needs DIV/2 cens to rise
    chk("rgb1_before_rst", 32'(rgb1_o), 32'h00B56BD6);
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_clk1_lo", 32'(rgbclk1), 32'd0);
    chk("post_rst_rgb1_lo", 32'(rgb1_o), 32'd0);
    repeat (2) tick();
    chk("post_rst_clk1_hi", 32'(rgbclk1), 32'd1);
    chk("post_rst_rgb1", 32'(rgb1_o), 32'h00B56BD6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
